// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller.
// Holds the FSM state type, the comparator response encoding and a helper
// that flags comparator responses that are not exactly one-hot.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Response vector layout is {eq, gt, lt}.
    localparam logic [2:0] RESP_EQ = 3'b100;
    localparam logic [2:0] RESP_GT = 3'b010;
    localparam logic [2:0] RESP_LT = 3'b001;

    // A sane comparator asserts exactly one of eq/gt/lt.
    function automatic logic resp_illegal(input logic [2:0] resp);
        return !((resp == RESP_EQ) || (resp == RESP_GT) || (resp == RESP_LT));
    endfunction

endpackage

// File: rtl/sar_wait_timer.sv
// Comparator-latency timer for sar_search_ctrl.
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   load      - high in TRY: arms the counter for the WAIT phase
//   run       - high in WAIT: counter decrements toward zero
//   sample    - strobe marking the cycle on which the comparator is valid
// With CMP_LAT = 0 the strobe is simply the TRY cycle itself; the counter is
// then dead logic and is optimised away.
module sar_wait_timer #(
    parameter int CMP_LAT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic sample
);

    // WAIT spans CMP_LAT cycles and the strobe fires when the count is zero,
    // so the counter starts at CMP_LAT-1.
    localparam logic [1:0] LOAD_VAL = 2'((CMP_LAT > 0) ? CMP_LAT - 1 : 0);

    logic [1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (run && (cnt != 2'd0)) begin
            cnt <= cnt - 2'd1;
        end
    end

    assign sample = (CMP_LAT == 0) ? load : (run && (cnt == 2'd0));

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller.
// Drives a trial value to an external magnitude comparator (target on its a
// input, guess on b), resolves one bit per step MSB first, and reports the
// recovered target.
// Ports:
//   clk, rst              - system clock, asynchronous active-high reset
//   start                 - begin a search (sampled in IDLE only)
//   cmp_eq/cmp_gt/cmp_lt  - comparator response: target ==/>/< guess
//   guess                 - trial value, 0 outside a search
//   busy                  - high in TRY/WAIT
//   done                  - one-cycle pulse when a search ends
//   err                   - illegal comparator response seen; held to next start
//   result                - recovered target; held to next start
//   steps                 - comparisons used; held to next start
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CMP_LAT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       cmp_eq,
    input  logic                       cmp_gt,
    input  logic                       cmp_lt,
    output logic [WIDTH-1:0]           guess,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [WIDTH-1:0]           result,
    output logic [$clog2(WIDTH+1)-1:0] steps
);

    localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int STEPS_W = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;
    logic [STEPS_W-1:0] steps_q, steps_d;

    logic [WIDTH-1:0]   trial;
    logic [WIDTH-1:0]   acc_kept;
    logic [2:0]         resp;
    logic               sample;

    assign trial    = acc_q | (WIDTH'(1) << idx_q);
    assign resp     = {cmp_eq, cmp_gt, cmp_lt};
    // A "gt" answer means the target lies at or above the trial: keep bit i.
    assign acc_kept = (resp == RESP_GT) ? trial : acc_q;

    sar_wait_timer #(
        .CMP_LAT (CMP_LAT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state_q == TRY),
        .run    (state_q == WAIT),
        .sample (sample)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            result_q <= '0;
            idx_q    <= IDX_TOP;
            err_q    <= 1'b0;
            steps_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            steps_q  <= steps_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        idx_d    = idx_q;
        err_d    = err_q;
        steps_d  = steps_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = TRY;
                    acc_d   = '0;
                    idx_d   = IDX_TOP;
                    err_d   = 1'b0;
                    steps_d = '0;
                end
            end

            TRY, WAIT: begin
                if (sample) begin
                    steps_d = steps_q + 1'b1;
                    if (resp_illegal(resp)) begin
                        err_d    = 1'b1;
                        result_d = acc_q;
                        state_d  = DONE;
                    end else if (resp == RESP_EQ) begin
                        result_d = trial;
                        state_d  = DONE;
                    end else begin
                        acc_d = acc_kept;
                        if (idx_q == '0) begin
                            result_d = acc_kept;
                            state_d  = DONE;
                        end else begin
                            idx_d   = idx_q - 1'b1;
                            state_d = TRY;
                        end
                    end
                end else begin
                    // Only reachable with CMP_LAT > 0: hold the guess while
                    // the comparator settles.
                    state_d = WAIT;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q == TRY) || (state_q == WAIT);
    assign done   = (state_q == DONE);
    assign guess  = busy ? trial : '0;
    assign err    = err_q;
    assign result = result_q;
    assign steps  = steps_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: one instance with CMP_LAT=0 and
// one with CMP_LAT=2, each paired with a behavioural WIDTH-bit comparator
// (the latency-2 one answers from a guess delayed by two clocks). Expected
// guess sequences, results, step counts and latencies come from closed-form
// arithmetic on the target value.
module tb_sar_search_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic inj = 1'b0;
    logic cur = 1'b0;

    always #5 clk = ~clk;

    logic [W-1:0] target0 = '0, target2 = '0;
    logic [W-1:0] g2_d1, g2_d2;
    logic         eq0, gt0, lt0, eq2, gt2, lt2;
    logic [W-1:0] guess0, guess2, result0, result2;
    logic         busy0, busy2, done0, done2, err0, err2;
    logic [2:0]   steps0, steps2;

    logic [W-1:0] m_guess, m_result;
    logic         m_busy, m_done, m_err;
    logic [2:0]   m_steps;

    sar_search_ctrl #(.WIDTH(W), .CMP_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start & ~cur),
        .cmp_eq(eq0), .cmp_gt(gt0), .cmp_lt(lt0),
        .guess(guess0), .busy(busy0), .done(done0), .err(err0),
        .result(result0), .steps(steps0)
    );

    sar_search_ctrl #(.WIDTH(W), .CMP_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start & cur),
        .cmp_eq(eq2), .cmp_gt(gt2), .cmp_lt(lt2),
        .guess(guess2), .busy(busy2), .done(done2), .err(err2),
        .result(result2), .steps(steps2)
    );

    // Comparator with two cycles of latency for dut2.
    always @(posedge clk) begin
        g2_d1 <= guess2;
        g2_d2 <= g2_d1;
    end

    always_comb begin
        {eq0, gt0, lt0} = {target0 == guess0, target0 > guess0, target0 < guess0};
        if (inj) {eq0, gt0, lt0} = 3'b110;
        {eq2, gt2, lt2} = {target2 == g2_d2, target2 > g2_d2, target2 < g2_d2};
        if (inj) {eq2, gt2, lt2} = 3'b110;
    end

    always_comb begin
        m_guess  = cur ? guess2  : guess0;
        m_result = cur ? result2 : result0;
        m_busy   = cur ? busy2   : busy0;
        m_done   = cur ? done2   : done0;
        m_err    = cur ? err2    : err0;
        m_steps  = cur ? steps2  : steps0;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Comparisons needed to find t: the search ends on eq at t's lowest set
    // bit, or after all W bits when t is zero.
    function automatic int ref_steps(input int t);
        if (t == 0) return W;
        for (int b = 0; b < W; b++) if (t[b]) return W - b;
        return W;
    endfunction

    // k-th trial (1-based): t's bits above position W-k, plus bit W-k set.
    function automatic int ref_guess(input int t, input int k);
        int b = W - k;
        return (t & ~((1 << (b + 1)) - 1)) | (1 << b);
    endfunction

    // Bits of t resolved after s-1 decisions.
    function automatic int ref_prefix(input int t, input int s);
        return t & ~((1 << (W - s + 1)) - 1);
    endfunction

    // One full search; bad > 0 makes sample number 'bad' illegal (eq+gt).
    task automatic run_search(input logic sel, input int t, input int bad, input int lat);
        int  exp_steps, exp_res, exp_err, k;
        bit  seen;
        cur = sel;
        if (sel) target2 = W'(t); else target0 = W'(t);
        exp_steps = (bad > 0) ? bad : ref_steps(t);
        exp_res   = (bad > 0) ? ref_prefix(t, bad) : t;
        exp_err   = (bad > 0) ? 1 : 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int n = 1; n <= 80 && !seen; n++) begin
            if (m_done) begin
                seen = 1'b1;
                inj  = 1'b0;
                check("latency", n, exp_steps * (lat + 1) + 1);
                check("result", int'(m_result), exp_res);
                check("steps", int'(m_steps), exp_steps);
                check("err", int'(m_err), exp_err);
                check("busy_in_done", int'(m_busy), 0);
                check("guess_in_done", int'(m_guess), 0);
            end else begin
                k = (n - 1) / (lat + 1) + 1;
                check("busy", int'(m_busy), 1);
                check("guess", int'(m_guess), ref_guess(t, k));
                if (n == 1) begin
                    check("err_cleared", int'(m_err), 0);
                    check("steps_cleared", int'(m_steps), 0);
                end
                inj = (bad > 0) && (k == bad);
                @(negedge clk);
            end
        end
        if (!seen) begin
            inj = 1'b0;
            check("done_timeout", 0, 1);
        end
        @(negedge clk);
        check("done_pulse_width", int'(m_done), 0);
        check("idle_busy", int'(m_busy), 0);
        check("result_held", int'(m_result), exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, bad, sel;

        // Asynchronous reset with no clock edge yet.
        #2 rst = 1'b1;
        #1;
        check("rst_guess0", int'(guess0), 0);
        check("rst_busy0", int'(busy0), 0);
        check("rst_done0", int'(done0), 0);
        check("rst_err0", int'(err0), 0);
        check("rst_result0", int'(result0), 0);
        check("rst_steps0", int'(steps0), 0);
        check("rst_guess2", int'(guess2), 0);
        check("rst_busy2", int'(busy2), 0);
        check("rst_done2", int'(done2), 0);
        check("rst_result2", int'(result2), 0);
        check("rst_steps2", int'(steps2), 0);
        @(negedge clk) rst = 1'b0;

        // Directed cases.
        run_search(1'b0, 11, 0, 0);
        run_search(1'b0, 8, 0, 0);
        run_search(1'b0, 0, 0, 0);
        run_search(1'b0, 15, 0, 0);
        run_search(1'b1, 5, 0, 2);
        run_search(1'b0, 11, 2, 0);
        run_search(1'b0, 11, 0, 0);

        // Full sweep on the zero-latency instance.
        for (int i = 0; i < 16; i++) run_search(1'b0, i, 0, 0);

        // Randomised targets, instances and occasional illegal responses.
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 1);
            t   = $urandom_range(0, 15);
            bad = 0;
            if (ref_steps(t) > 1 && $urandom_range(0, 3) == 0)
                bad = $urandom_range(1, ref_steps(t) - 1);
            run_search(sel[0], t, bad, (sel != 0) ? 2 : 0);
        end

        // Asynchronous reset mid-search, right after guess reaches 12.
        cur = 1'b0;
        target0 = 4'd11;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("abort_guess1", int'(guess0), 8);
        @(negedge clk);
        check("abort_guess2", int'(guess0), 12);
        #2 rst = 1'b1;
        #1;
        check("abort_guess", int'(guess0), 0);
        check("abort_busy", int'(busy0), 0);
        check("abort_done", int'(done0), 0);
        check("abort_err", int'(err0), 0);
        check("abort_result", int'(result0), 0);
        check("abort_steps", int'(steps0), 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("abort_idle_busy", int'(busy0), 0);

        // start during busy and during DONE must be ignored.
        target0 = 4'd11;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("nostart_busy_guess", int'(guess0), 10);
        @(negedge clk);
        check("nostart_busy_guess4", int'(guess0), 11);
        @(negedge clk);
        check("nostart_done", int'(done0), 1);
        check("nostart_result", int'(result0), 11);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("nostart_after_done_busy", int'(busy0), 0);
        check("nostart_after_done_done", int'(done0), 0);
        check("nostart_after_done_guess", int'(guess0), 0);
        @(negedge clk);
        check("nostart_still_idle", int'(busy0), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
